// File: rtl/mem_bus_pkg.sv
// Bus command encoding, tag constants and the delay-line entry type
// shared by mem_responder and mem_resp_pipe.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int TAG_W = 4;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } resp_t;

  // Tags cycle 1..15; 0 is reserved for "no tag".
  function automatic logic [TAG_W-1:0] tag_inc(
    input logic [TAG_W-1:0] t
  );
    return (t == '1) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth delay line carrying {valid, tag, data} for load returns.
// Cleared by reset so in-flight loads are dropped.
module mem_resp_pipe
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  resp_t in_ent,
  output resp_t out_ent
);

  resp_t stage [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_ent;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_ent = stage[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Tagged fixed-latency memory model with backdoor preload.
// Define MEM_RESP_BOUNDS_EN to reject out-of-range addresses (adds mem_err).
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MAX_OUT     = 4,
  parameter int MEM_WORDS   = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2mem_command,
  input  logic [63:0]      proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2proc_response,
  output logic [63:0]      mem2proc_data,
  output logic [TAG_W-1:0] mem2proc_tag,
  input  logic             preload_en,
  input  logic [63:0]      preload_addr,
  input  logic [63:0]      preload_data
`ifdef MEM_RESP_BOUNDS_EN
  ,
  output logic             mem_err
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = 4;

  logic [63:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pre_idx;
  logic             is_load;
  logic             is_store;
  logic             in_range;
  logic             load_ok;
  logic             store_ok;
  logic             accept;
  logic             done;
  logic [CNT_W-1:0] out_cnt;
  logic [TAG_W-1:0] next_tag;
  resp_t            pipe_in;
  resp_t            pipe_out;
  logic             unused_bits;

  assign idx      = proc2mem_addr[3 +: IDX_W];
  assign pre_idx  = preload_addr[3 +: IDX_W];
  assign is_load  = proc2mem_command == BUS_LOAD;
  assign is_store = proc2mem_command == BUS_STORE;

`ifdef MEM_RESP_BOUNDS_EN
  assign in_range = (proc2mem_addr >> (IDX_W + 3)) == 64'd0;
`else
  assign in_range = 1'b1;
`endif

  assign load_ok  = reset && is_load && in_range &&
                    (out_cnt < CNT_W'(MAX_OUT));
  assign store_ok = reset && is_store && in_range;
  assign accept   = load_ok || store_ok;

  assign mem2proc_response = accept ? next_tag : NO_TAG;

  assign pipe_in = '{valid: load_ok, tag: next_tag, data: mem[idx]};

  mem_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .in_ent  (pipe_in),
    .out_ent (pipe_out)
  );

  assign done          = pipe_out.valid;
  assign mem2proc_tag  = done ? pipe_out.tag : NO_TAG;
  assign mem2proc_data = done ? pipe_out.data : 64'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_cnt  <= '0;
      next_tag <= TAG_W'(1);
    end else begin
      unique case ({load_ok, done})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (accept) begin
        next_tag <= tag_inc(next_tag);
      end
    end
  end

  // Storage survives reset; the later store write overrides preload.
  always_ff @(posedge clock) begin
    if (preload_en) begin
      mem[pre_idx] <= preload_data;
    end
    if (store_ok) begin
      mem[idx] <= proc2mem_data;
    end
  end

`ifdef MEM_RESP_BOUNDS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_err <= 1'b0;
    end else if ((is_load || is_store) && !in_range) begin
      mem_err <= 1'b1;
    end
  end
`endif

  assign unused_bits = ^{proc2mem_addr[2:0],
                         proc2mem_addr[63:IDX_W+3],
                         preload_addr[2:0],
                         preload_addr[63:IDX_W+3]};

endmodule
